// File: rtl/accumulator_seq_control_if.sv
// rtl/accumulator_seq_control_if.sv - datapath handshake/strobe bundle for the accumulator sequencer
interface accumulator_seq_control_if #(
    parameter int OPC_BITS = 4,
    parameter int ALU_BITS = 2
);
    logic [OPC_BITS-1:0] i_opcode;
    logic                i_acc_zero;
    logic                i_mem_ready;
    logic                i_step_mode;
    logic                i_step;
    logic                o_ld_mar;
    logic                o_ld_mdr;
    logic                o_ld_ir;
    logic                o_ld_pc;
    logic                o_ld_acc;
    logic                o_mux_pc_ird;
    logic                o_mux_ir_p1;
    logic                o_mux_mdr_alur;
    logic [ALU_BITS-1:0] o_alu_ctrl;
    logic                o_mem_rd;
    logic                o_mem_wr;
    logic                o_halted;
    logic                o_fault;
    logic [3:0]          o_state;

    // Datapath/bench side: drives opcode and status, observes strobes
    modport master (
        output i_opcode, i_acc_zero, i_mem_ready, i_step_mode, i_step,
        input  o_ld_mar, o_ld_mdr, o_ld_ir, o_ld_pc, o_ld_acc,
               o_mux_pc_ird, o_mux_ir_p1, o_mux_mdr_alur, o_alu_ctrl,
               o_mem_rd, o_mem_wr, o_halted, o_fault, o_state
    );

    // Controller side
    modport slave (
        input  i_opcode, i_acc_zero, i_mem_ready, i_step_mode, i_step,
        output o_ld_mar, o_ld_mdr, o_ld_ir, o_ld_pc, o_ld_acc,
               o_mux_pc_ird, o_mux_ir_p1, o_mux_mdr_alur, o_alu_ctrl,
               o_mem_rd, o_mem_wr, o_halted, o_fault, o_state
    );
endinterface

// File: rtl/accumulator_seq_control.sv
// rtl/accumulator_seq_control.sv - multi-cycle control FSM for the accumulator CPU
module accumulator_seq_control #(
    parameter int OPC_BITS   = 4,
    parameter int ALU_BITS   = 2,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    accumulator_seq_control_if.slave  bus
);
    typedef enum logic [3:0] {
        S_FETCH_ADDR = 4'd0,
        S_FETCH_MEM  = 4'd1,
        S_DECODE     = 4'd2,
        S_DISPATCH   = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_MEM     = 4'd5,
        S_OP_ACC     = 4'd6,
        S_JUMP       = 4'd7,
        S_INC_PC     = 4'd8,
        S_PAUSE      = 4'd9,
        S_HALT       = 4'd10,
        S_FAULT      = 4'd11
    } state_t;

    localparam logic [OPC_BITS-1:0] OP_NOP = OPC_BITS'(0);
    localparam logic [OPC_BITS-1:0] OP_LDA = OPC_BITS'(1);
    localparam logic [OPC_BITS-1:0] OP_STA = OPC_BITS'(2);
    localparam logic [OPC_BITS-1:0] OP_ADD = OPC_BITS'(3);
    localparam logic [OPC_BITS-1:0] OP_SUB = OPC_BITS'(4);
    localparam logic [OPC_BITS-1:0] OP_JMP = OPC_BITS'(5);
    localparam logic [OPC_BITS-1:0] OP_JZ  = OPC_BITS'(6);
    localparam logic [OPC_BITS-1:0] OP_HLT = OPC_BITS'(7);

    // Counter only needs to reach WAIT_LIMIT; it saturates at all-ones so a
    // disabled limit (0) can wait forever without wrapping.
    localparam int              CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    state_t              r_state;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [CNT_W-1:0]    w_wait_inc;
    logic                w_timeout;
    logic [OPC_BITS-1:0] w_opcode;
    logic                w_is_sta;

    assign w_opcode   = bus.i_opcode;
    assign w_is_sta   = (w_opcode == OP_STA);
    assign w_wait_inc = (r_wait_cnt == {CNT_W{1'b1}}) ? r_wait_cnt : r_wait_cnt + 1'b1;
    assign w_timeout  = (WAIT_LIMIT != 0) && (w_wait_inc == LIMIT);

    // State sequencing and memory wait counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_FETCH_ADDR;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_FETCH_ADDR: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_FETCH_MEM;
                end
                S_FETCH_MEM: begin
                    if (bus.i_mem_ready) begin
                        r_state <= S_DECODE;
                    end else begin
                        r_wait_cnt <= w_wait_inc;
                        if (w_timeout) r_state <= S_FAULT;
                    end
                end
                S_DECODE: r_state <= S_DISPATCH;
                S_DISPATCH: begin
                    case (w_opcode)
                        OP_NOP:  r_state <= S_INC_PC;
                        OP_HLT:  r_state <= S_HALT;
                        OP_JMP:  r_state <= S_JUMP;
                        OP_JZ:   r_state <= bus.i_acc_zero ? S_JUMP : S_INC_PC;
                        OP_LDA,
                        OP_STA,
                        OP_ADD,
                        OP_SUB:  r_state <= S_OP_ADDR;
                        default: r_state <= S_FAULT;
                    endcase
                end
                S_OP_ADDR: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_OP_MEM;
                end
                S_OP_MEM: begin
                    if (bus.i_mem_ready) begin
                        r_state <= w_is_sta ? S_INC_PC : S_OP_ACC;
                    end else begin
                        r_wait_cnt <= w_wait_inc;
                        if (w_timeout) r_state <= S_FAULT;
                    end
                end
                S_OP_ACC: r_state <= S_INC_PC;
                S_JUMP:   r_state <= S_FETCH_ADDR;
                S_INC_PC: r_state <= bus.i_step_mode ? S_PAUSE : S_FETCH_ADDR;
                S_PAUSE: begin
                    if (bus.i_step || !bus.i_step_mode) r_state <= S_FETCH_ADDR;
                end
                S_HALT:   r_state <= S_HALT;
                S_FAULT:  r_state <= S_FAULT;
                default:  r_state <= S_FAULT;
            endcase
        end
    end

    logic                w_ld_mar;
    logic                w_ld_mdr;
    logic                w_ld_ir;
    logic                w_ld_pc;
    logic                w_ld_acc;
    logic                w_mux_pc_ird;
    logic                w_mux_ir_p1;
    logic                w_mux_mdr_alur;
    logic [ALU_BITS-1:0] w_alu_ctrl;
    logic                w_mem_rd;
    logic                w_mem_wr;
    logic                w_halted;
    logic                w_fault;
    logic [3:0]          w_state;

    // Moore strobe decode; ld_mdr qualifies on the ready cycle so MDR captures
    // exactly once, and everything is forced low while reset is held.
    always_comb begin
        w_ld_mar       = 1'b0;
        w_ld_mdr       = 1'b0;
        w_ld_ir        = 1'b0;
        w_ld_pc        = 1'b0;
        w_ld_acc       = 1'b0;
        w_mux_pc_ird   = 1'b0;
        w_mux_ir_p1    = 1'b0;
        w_mux_mdr_alur = 1'b0;
        w_alu_ctrl     = '0;
        w_mem_rd       = 1'b0;
        w_mem_wr       = 1'b0;
        w_halted       = 1'b0;
        w_fault        = 1'b0;
        w_state        = r_state;
        case (r_state)
            S_FETCH_ADDR: w_ld_mar = 1'b1;
            S_FETCH_MEM: begin
                w_mem_rd = 1'b1;
                w_ld_mdr = bus.i_mem_ready;
            end
            S_DECODE:  w_ld_ir = 1'b1;
            S_OP_ADDR: begin
                w_ld_mar     = 1'b1;
                w_mux_pc_ird = 1'b1;
            end
            S_OP_MEM: begin
                if (w_is_sta) begin
                    w_mem_wr = 1'b1;
                end else begin
                    w_mem_rd = 1'b1;
                    w_ld_mdr = bus.i_mem_ready;
                end
            end
            S_OP_ACC: begin
                w_ld_acc       = 1'b1;
                w_mux_mdr_alur = (w_opcode != OP_LDA);
                w_alu_ctrl     = (w_opcode == OP_SUB) ? ALU_BITS'(1) : ALU_BITS'(0);
            end
            S_JUMP: begin
                w_ld_pc     = 1'b1;
                w_mux_ir_p1 = 1'b1;
            end
            S_INC_PC: w_ld_pc = 1'b1;
            S_HALT:   w_halted = 1'b1;
            S_FAULT: begin
                w_halted = 1'b1;
                w_fault  = 1'b1;
            end
            default: ;
        endcase
        if (i_rst) begin
            w_ld_mar       = 1'b0;
            w_ld_mdr       = 1'b0;
            w_ld_ir        = 1'b0;
            w_ld_pc        = 1'b0;
            w_ld_acc       = 1'b0;
            w_mux_pc_ird   = 1'b0;
            w_mux_ir_p1    = 1'b0;
            w_mux_mdr_alur = 1'b0;
            w_alu_ctrl     = '0;
            w_mem_rd       = 1'b0;
            w_mem_wr       = 1'b0;
            w_halted       = 1'b0;
            w_fault        = 1'b0;
            w_state        = 4'd0;
        end
    end

    assign bus.o_ld_mar       = w_ld_mar;
    assign bus.o_ld_mdr       = w_ld_mdr;
    assign bus.o_ld_ir        = w_ld_ir;
    assign bus.o_ld_pc        = w_ld_pc;
    assign bus.o_ld_acc       = w_ld_acc;
    assign bus.o_mux_pc_ird   = w_mux_pc_ird;
    assign bus.o_mux_ir_p1    = w_mux_ir_p1;
    assign bus.o_mux_mdr_alur = w_mux_mdr_alur;
    assign bus.o_alu_ctrl     = w_alu_ctrl;
    assign bus.o_mem_rd       = w_mem_rd;
    assign bus.o_mem_wr       = w_mem_wr;
    assign bus.o_halted       = w_halted;
    assign bus.o_fault        = w_fault;
    assign bus.o_state        = w_state;
endmodule

// File: tb/tb_accumulator_seq_control.sv
// tb/tb_accumulator_seq_control.sv - scoreboard bench for the accumulator sequencer
module tb_accumulator_seq_control;
    localparam logic [3:0] S_FA = 4'd0, S_FM = 4'd1, S_DEC = 4'd2, S_DISP = 4'd3;
    localparam logic [3:0] S_OPA = 4'd4, S_OPM = 4'd5, S_OPACC = 4'd6, S_JUMP = 4'd7;
    localparam logic [3:0] S_INC = 4'd8, S_PAUSE = 4'd9, S_HALT = 4'd10, S_FAULT = 4'd11;

    localparam logic [13:0] M_LD_MAR  = 14'h2000, M_LD_MDR   = 14'h1000, M_LD_IR    = 14'h0800;
    localparam logic [13:0] M_LD_PC   = 14'h0400, M_LD_ACC   = 14'h0200, M_MUX_PCIR = 14'h0100;
    localparam logic [13:0] M_MUX_IRP = 14'h0080, M_MUX_ALUR = 14'h0040, M_ALU_SUB  = 14'h0010;
    localparam logic [13:0] M_MEM_RD  = 14'h0008, M_MEM_WR   = 14'h0004, M_HALTED   = 14'h0002;
    localparam logic [13:0] M_FAULT   = 14'h0001;

    typedef struct packed {
        logic [3:0]  st;
        logic [13:0] sig;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t       exp_q[$];
    logic [7:0] stim_q[$];
    string      tag_q[$];
    string      cur_tag;

    accumulator_seq_control_if #(.OPC_BITS(4), .ALU_BITS(2)) bus ();
    accumulator_seq_control_if #(.OPC_BITS(4), .ALU_BITS(2)) bus2 ();

    accumulator_seq_control #(.OPC_BITS(4), .ALU_BITS(2), .WAIT_LIMIT(15)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    accumulator_seq_control #(.OPC_BITS(4), .ALU_BITS(2), .WAIT_LIMIT(0)) u_dut_nolimit (
        .i_clk (clk),
        .i_rst (rst2),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    logic [17:0] w_obs;
    assign w_obs = {bus.o_state, bus.o_ld_mar, bus.o_ld_mdr, bus.o_ld_ir, bus.o_ld_pc,
                    bus.o_ld_acc, bus.o_mux_pc_ird, bus.o_mux_ir_p1, bus.o_mux_mdr_alur,
                    bus.o_alu_ctrl, bus.o_mem_rd, bus.o_mem_wr, bus.o_halted, bus.o_fault};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [13:0] sig, input logic [7:0] stim);
        exp_t e;
        e.st  = st;
        e.sig = sig;
        exp_q.push_back(e);
        stim_q.push_back(stim);
        tag_q.push_back(cur_tag);
    endtask

    // stimulus byte: {opcode, acc_zero, step_mode, step, mem_ready}
    function automatic logic [7:0] rnd_stim(input logic [3:0] op, input logic z, input logic sm);
        return {op, z, sm, 2'($urandom_range(0, 3))};
    endfunction

    function automatic logic [7:0] wait_stim(input logic [3:0] op, input logic z, input logic sm);
        return {op, z, sm, 1'($urandom_range(0, 1)), 1'b0};
    endfunction

    // Reference sequence of one instruction; fw/ow are not-ready cycles on
    // the fetch/operand access, hold is the cycle count kept in HALT/FAULT.
    task automatic build_instr(input string tag, input logic [3:0] op, input logic z,
                               input int fw, input int ow, input logic sm,
                               input int pause_n, input logic rel_mode, input int hold);
        logic tail;
        logic is_sta;
        tail    = 1'b0;
        is_sta  = (op == 4'd2);
        cur_tag = tag;
        push(S_FA, M_LD_MAR, rnd_stim(op, z, sm));
        for (int i = 0; i < fw && i < 15; i++) push(S_FM, M_MEM_RD, wait_stim(op, z, sm));
        if (fw >= 15) begin
            for (int i = 0; i < hold; i++) push(S_FAULT, M_HALTED | M_FAULT, 8'($urandom_range(0, 255)));
        end else begin
            push(S_FM, M_MEM_RD | M_LD_MDR, {op, z, sm, 1'b0, 1'b1});
            push(S_DEC, M_LD_IR, rnd_stim(op, z, sm));
            push(S_DISP, 14'h0, {op, z, sm, 2'($urandom_range(0, 3))});
            case (op)
                4'd0: tail = 1'b1;
                4'd5: push(S_JUMP, M_LD_PC | M_MUX_IRP, rnd_stim(op, z, sm));
                4'd6: if (z) push(S_JUMP, M_LD_PC | M_MUX_IRP, rnd_stim(op, z, sm));
                      else tail = 1'b1;
                4'd7: for (int i = 0; i < hold; i++) push(S_HALT, M_HALTED, 8'($urandom_range(0, 255)));
                4'd1, 4'd2, 4'd3, 4'd4: begin
                    push(S_OPA, M_LD_MAR | M_MUX_PCIR, rnd_stim(op, z, sm));
                    for (int i = 0; i < ow; i++)
                        push(S_OPM, is_sta ? M_MEM_WR : M_MEM_RD, wait_stim(op, z, sm));
                    push(S_OPM, is_sta ? M_MEM_WR : (M_MEM_RD | M_LD_MDR), {op, z, sm, 1'b0, 1'b1});
                    if (!is_sta)
                        push(S_OPACC, M_LD_ACC | ((op == 4'd1) ? 14'h0 : M_MUX_ALUR) |
                             ((op == 4'd4) ? M_ALU_SUB : 14'h0), rnd_stim(op, z, sm));
                    tail = 1'b1;
                end
                default: for (int i = 0; i < hold; i++) push(S_FAULT, M_HALTED | M_FAULT, 8'($urandom_range(0, 255)));
            endcase
            if (tail) begin
                push(S_INC, M_LD_PC, rnd_stim(op, z, sm));
                if (sm) begin
                    for (int i = 0; i < pause_n; i++)
                        push(S_PAUSE, 14'h0, {op, z, 1'b1, 1'b0, 1'($urandom_range(0, 1))});
                    push(S_PAUSE, 14'h0, rel_mode ? {op, z, 2'b00, 1'($urandom_range(0, 1))}
                                                  : {op, z, 2'b11, 1'($urandom_range(0, 1))});
                end
            end
        end
    endtask

    // Drive each queued cycle, compare the popped expectation at the falling edge
    task automatic run_q();
        while (exp_q.size() > 0) begin
            exp_t       e;
            logic [7:0] s;
            string      t;
            e = exp_q.pop_front();
            s = stim_q.pop_front();
            t = tag_q.pop_front();
            {bus.i_opcode, bus.i_acc_zero, bus.i_step_mode, bus.i_step, bus.i_mem_ready} = s;
            @(negedge clk);
            check(t, 32'(w_obs), 32'(e));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        {bus.i_opcode, bus.i_acc_zero, bus.i_step_mode, bus.i_step, bus.i_mem_ready} = 8'($urandom_range(0, 255));
        #1;
        check(tag, 32'(w_obs), 32'h0);
        @(posedge clk);
        #1;
        check({tag, "_held"}, 32'(w_obs), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        bus2.i_opcode    = 4'd0;
        bus2.i_acc_zero  = 1'b0;
        bus2.i_mem_ready = 1'b0;
        bus2.i_step_mode = 1'b0;
        bus2.i_step      = 1'b0;
        {bus.i_opcode, bus.i_acc_zero, bus.i_step_mode, bus.i_step, bus.i_mem_ready} = 8'h0;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        do_reset("reset");

        build_instr("nop",       4'd0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
        build_instr("add_wait3", 4'd3, 1'b0, 0, 3, 1'b0, 0, 1'b0, 0);
        build_instr("lda",       4'd1, 1'b1, 0, 0, 1'b0, 0, 1'b0, 0);
        build_instr("sub",       4'd4, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
        build_instr("sta_wait2", 4'd2, 1'b0, 0, 2, 1'b0, 0, 1'b0, 0);
        build_instr("jmp",       4'd5, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
        build_instr("jz_taken",  4'd6, 1'b1, 0, 0, 1'b0, 0, 1'b0, 0);
        build_instr("jz_not",    4'd6, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
        build_instr("nop_fwait", 4'd0, 1'b0, 2, 0, 1'b0, 0, 1'b0, 0);
        build_instr("step_nop",  4'd0, 1'b0, 0, 0, 1'b1, 4, 1'b0, 0);
        build_instr("step_jz",   4'd6, 1'b0, 0, 0, 1'b1, 2, 1'b1, 0);
        build_instr("step_lda",  4'd1, 1'b0, 1, 1, 1'b1, 0, 1'b0, 0);
        build_instr("halt",      4'd7, 1'b0, 0, 0, 1'b0, 0, 1'b0, 20);
        run_q();
        do_reset("reset_halt");

        build_instr("illegal9",  4'd9, 1'b0, 0, 0, 1'b0, 0, 1'b0, 4);
        run_q();
        do_reset("reset_fault");

        build_instr("timeout",   4'd0, 1'b0, 15, 0, 1'b0, 0, 1'b0, 3);
        run_q();
        do_reset("reset_timeout");

        cur_tag = "pre_rst_opmem";
        push(S_FA,  M_LD_MAR,               8'h10);
        push(S_FM,  M_MEM_RD | M_LD_MDR,    8'h11);
        push(S_DEC, M_LD_IR,                8'h10);
        push(S_DISP, 14'h0,                 8'h10);
        push(S_OPA, M_LD_MAR | M_MUX_PCIR,  8'h10);
        push(S_OPM, M_MEM_RD,               8'h10);
        push(S_OPM, M_MEM_RD,               8'h10);
        run_q();
        check("still_opmem", 32'(bus.o_state), 32'(S_OPM));
        rst = 1'b1;
        #1;
        check("rst_in_opmem", 32'(w_obs), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        check("nolimit_state", 32'(bus2.o_state), 32'(S_FM));
        check("nolimit_fault", 32'(bus2.o_fault), 32'h0);
        check("nolimit_rd",    32'(bus2.o_mem_rd), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
